// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD-to-binary converter.
package bcd_pkg;

    localparam int unsigned DigitWidth    = 4;
    localparam int unsigned DefaultDigits = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StShift = 3'b010,
        StDone  = 3'b100
    } state_e;

    function automatic logic bcd_digit_valid(input logic [DigitWidth-1:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Per-digit reverse double-dabble correction: digits of 8 or more drop by 3.
module bcd_sub3
    import bcd_pkg::*;
(
    input  logic [DigitWidth-1:0] digit,
    output logic [DigitWidth-1:0] adjusted
);

    assign adjusted = (digit >= 4'd8) ? digit - 4'd3 : digit;

endmodule

// File: rtl/bcd_bin.sv
// Sequential packed-BCD to binary converter, one bit per cycle, start/done handshake.
module bcd_bin
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS    = DefaultDigits,
    parameter int unsigned CNT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tran_en,
    input  logic [DIGITS*DigitWidth-1:0] bcd_in,
    output logic                         tran_done,
    output logic                         busy,
    output logic                         err,
    output logic [DIGITS*DigitWidth-1:0] data_out
);

    localparam int unsigned W = DIGITS * DigitWidth;

    state_e               state;
    logic [W-1:0]         bcd_reg;
    logic [W-1:0]         bin_reg;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W-1:0]         bcd_shr;
    logic [W-1:0]         bcd_adj;
    logic [W-1:0]         bin_shr;
    logic                 in_valid;

    always_comb begin
        in_valid = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(bcd_in[i*DigitWidth +: DigitWidth])) begin
                in_valid = 1'b0;
            end
        end
    end

    // The {bcd_reg, bin_reg} pair shifts right as one 2W-bit register.
    assign bcd_shr = {1'b0, bcd_reg[W-1:1]};
    assign bin_shr = {bcd_reg[0], bin_reg[W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_sub3 u_sub3 (
            .digit    (bcd_shr[g*DigitWidth +: DigitWidth]),
            .adjusted (bcd_adj[g*DigitWidth +: DigitWidth])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            bcd_reg   <= '0;
            bin_reg   <= '0;
            cnt       <= '0;
            data_out  <= '0;
            err       <= 1'b0;
            tran_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (tran_en) begin
                        busy <= 1'b1;
                        if (in_valid) begin
                            bcd_reg <= bcd_in;
                            bin_reg <= '0;
                            cnt     <= '0;
                            state   <= StShift;
                        end else begin
                            // Bad digit: report straight away, keep the old result.
                            err       <= 1'b1;
                            tran_done <= 1'b1;
                            state     <= StDone;
                        end
                    end
                end
                StShift: begin
                    bcd_reg <= bcd_adj;
                    bin_reg <= bin_shr;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_WIDTH'(W - 1)) begin
                        data_out  <= bin_shr;
                        err       <= 1'b0;
                        tran_done <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    tran_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
                default: begin
                    tran_done <= 1'b0;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_bin.sv
// Randomised self-checking bench for bcd_bin against a decimal-arithmetic model.
module tb_bcd_bin;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tran_en;
    logic [W-1:0]  bcd_in;
    logic          tran_done;
    logic          busy;
    logic          err;
    logic [W-1:0]  data_out;

    int unsigned   passed = 0;
    int unsigned   total  = 0;
    logic [W-1:0]  prev_data = '0;

    bcd_bin #(
        .DIGITS    (4),
        .CNT_WIDTH (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tran_en   (tran_en),
        .bcd_in    (bcd_in),
        .tran_done (tran_done),
        .busy      (busy),
        .err       (err),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: interpret the packed digits as a decimal number.
    function automatic int unsigned bcd_value(input logic [W-1:0] b, output bit bad);
        int unsigned v = 0;
        int unsigned d;
        bad = 1'b0;
        for (int i = W/4 - 1; i >= 0; i--) begin
            d = (int'(b) >> (4*i)) & 15;
            if (d > 9) bad = 1'b1;
            v = v * 10 + d;
        end
        return v;
    endfunction

    task automatic run_conv(input logic [W-1:0] val);
        bit          bad;
        int unsigned exp_v;
        int          lat;
        int          busy_cnt;
        exp_v   = bcd_value(val, bad);
        tran_en = 1'b1;
        bcd_in  = val;
        tick();
        tran_en = 1'b0;
        bcd_in  = W'($urandom);
        check("busy_rise", busy, 1);
        if (bad) begin
            check("bad_done", tran_done, 1);
            check("bad_err", err, 1);
            check("bad_keep", data_out, prev_data);
            tick();
            check("bad_done_fall", tran_done, 0);
            check("bad_busy_fall", busy, 0);
        end else begin
            lat      = 0;
            busy_cnt = 1;
            while (!tran_done && lat < W + 4) begin
                tick();
                lat++;
                if (busy) busy_cnt++;
            end
            check("latency", lat, W);
            check("data", data_out, exp_v);
            check("err_clr", err, 0);
            prev_data = W'(exp_v);
            tick();
            check("done_fall", tran_done, 0);
            check("busy_len", busy_cnt, W + 1);
            check("busy_fall", busy, 0);
        end
    endtask

    initial begin
        logic [W-1:0] seq_in  [3];
        logic [W-1:0] seq_exp [3];
        logic [W-1:0] v;
        int           c;
        int           dones;
        logic [W-1:0] got_data;

        rst_n   = 1'b0;
        tran_en = 1'b0;
        bcd_in  = '0;
        #1;
        check("rst_data", data_out, 0);
        check("rst_err", err, 0);
        check("rst_done", tran_done, 0);
        check("rst_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        run_conv(16'h0000);
        run_conv(16'h9999);
        run_conv(16'h12A4);
        check("err_hold", err, 1);
        run_conv(16'h0042);

        // Continuous tran_en: accepts land every W+2 cycles.
        seq_in[0] = 16'h1234; seq_exp[0] = 16'h04D2;
        seq_in[1] = 16'h0010; seq_exp[1] = 16'h000A;
        seq_in[2] = 16'h0008; seq_exp[2] = 16'h0008;
        tran_en = 1'b1;
        bcd_in  = seq_in[0];
        tick();
        for (int n = 0; n < 3; n++) begin
            if (n > 0) begin
                tick();
                c = 1;
            end else begin
                c = 0;
            end
            while (!tran_done && c < 40) begin
                tick();
                c++;
            end
            check("seq_spacing", c, (n == 0) ? W : W + 2);
            check("seq_data", data_out, seq_exp[n]);
            if (n < 2) bcd_in = seq_in[n+1];
            else tran_en = 1'b0;
        end
        prev_data = seq_exp[2];
        repeat (2) tick();

        // Request and new data mid-conversion must be ignored.
        tran_en = 1'b1;
        bcd_in  = 16'h3141;
        tick();
        tran_en = 1'b0;
        repeat (5) tick();
        tran_en = 1'b1;
        bcd_in  = 16'h9876;
        tick();
        tran_en  = 1'b0;
        dones    = 0;
        got_data = '0;
        repeat (20) begin
            tick();
            if (tran_done) begin
                dones++;
                got_data = data_out;
            end
        end
        check("ignore_dones", dones, 1);
        check("ignore_data", got_data, 16'h0C45);

        // Reset in the middle of a conversion.
        tran_en = 1'b1;
        bcd_in  = 16'h5678;
        tick();
        tran_en = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("abort_data", data_out, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        check("abort_done", tran_done, 0);
        tick();
        rst_n = 1'b1;
        prev_data = '0;
        dones = 0;
        repeat (W + 4) begin
            tick();
            if (tran_done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_conv(16'h5678);

        // Random patterns, occasionally with a bad digit.
        repeat (30) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 7) == 0) v[4*d +: 4] = 4'($urandom_range(10, 15));
                else v[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            run_conv(v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_bin.md
# bcd_bin

Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that is 8 or greater. It is the inverse of the binary-to-BCD display converter. It takes packed decimal values from keypad and UART command paths and produces the binary values the control logic needs. It uses a start/done handshake, holds its result until the next conversion, and flags digits that are not valid BCD.

## Interface
- `DIGITS`, default 4: number of packed BCD digits. Input and output width W = 4*DIGITS.
- `CNT_WIDTH`, default 5: shift counter width. Must satisfy 2^CNT_WIDTH > W.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tran_en` in 1: start request. Sampled only in IDLE.
- `bcd_in` in W: packed BCD, most significant digit in the MSBs. Sampled on the accepting edge.
- `tran_done` out 1: one-cycle pulse, result valid.
- `busy` out 1: high whenever the state is not IDLE.
- `err` out 1: last conversion had a digit greater than 9. Held until the next `tran_done`.
- `data_out` out W: binary result, zero-extended (9999 needs 14 bits). Held until the next successful conversion.

## Operation
- FSM states: IDLE, SHIFT, DONE (one-hot, 3 bits).
  - IDLE, `tran_en`=1, all digits ≤ 9: load `bcd_reg` ← `bcd_in`, `bin_reg` ← 0, `cnt` ← 0, go to SHIFT.
  - IDLE, `tran_en`=1, any digit > 9: go to DONE with `err` ← 1. `data_out` unchanged.
  - IDLE, `tran_en`=0: stay.
  - SHIFT, each cycle:
    - Shift the {`bcd_reg`, `bin_reg`} pair right by 1, so `bcd_reg[0]` enters `bin_reg[W-1]`.
    - In the shifted `bcd_reg`, every digit ≥ 8 becomes digit − 3 (4-bit, no borrow across digits).
    - `cnt` ← `cnt` + 1.
    - When the shift with `cnt` = W−1 completes: `data_out` ← shifted `bin_reg`, `err` ← 0, go to DONE.
  - DONE: go to IDLE unconditionally.
- `tran_done` is 1 exactly while the state is DONE.
- `tran_en` in SHIFT or DONE is ignored, not queued. The earliest new accept is the first IDLE cycle.
- `bcd_in` changes after the accept edge have no effect.
- Only the accepting edge performs digit validation. Adjustment arithmetic never under- or overflows, because digits in the shifted register are ≤ 12 (8–12 → 5–9).
- Reset at any time: state → IDLE. All registers are cleared:
  - `data_out` = 0, `err` = 0, `tran_done` = 0, `busy` = 0.
  - `bcd_reg`, `bin_reg` and `cnt` cleared.
  - An aborted conversion produces no `tran_done`.

## Timing
- Let edge k be the edge that samples `tran_en`=1 in IDLE.
- Valid input:
  - Shifts occur on edges k+1 … k+W.
  - `data_out` is updated and DONE is entered on edge k+W.
  - `tran_done` is high for the cycle from edge k+W to edge k+W+1.
  - Latency is W cycles (16 at default).
- Invalid input:
  - DONE is entered on edge k; `tran_done` and `err` are high in the cycle after edge k.
- `busy` rises on edge k and falls on the edge leaving DONE.
- Minimum spacing between two accepts: W+2 cycles, with `tran_en` held high continuously.
- `data_out` and `err` change only on the edge entering DONE, so they are stable whenever `tran_done` is high.

## Structure
- Package `bcd_pkg`:
  - State encodings IDLE/SHIFT/DONE.
  - `DIGITS` default and the digit-width constant 4.
  - Function `bcd_digit_valid` (digit ≤ 9).
- Sub-module `bcd_sub3`: combinational 4-bit digit adjust (in ≥ 8 ? in − 3 : in). Instantiated DIGITS times via generate.
- Top level contains the FSM, counter, shift registers and output registers.

## Test plan
- Reset, then `bcd_in`=0x0000 with a 1-cycle `tran_en` → after 16 cycles `tran_done` pulses once; `data_out`=0x0000; `err`=0.
- `bcd_in`=0x9999 → `data_out`=0x270F (9999) exactly 16 cycles after the accept edge; `busy` high for 17 cycles.
- Sequence 0x1234 → 0x04D2, then 0x0010 → 0x000A, then 0x0008 → 0x0008. Drive `tran_en` continuously; accepts occur every 18 cycles.
- `bcd_in`=0x12A4 → `tran_done` and `err` high 1 cycle after accept; `data_out` keeps the previous result. The next valid conversion clears `err`.
- `tran_en` pulsed while `busy`, with `bcd_in` changed mid-conversion → ignored; the original result is produced; only one `tran_done`.
- `rst_n` asserted at shift 7 of a 0x5678 conversion → all outputs 0 immediately. No `tran_done` follows. A fresh conversion after release produces 0x162E.
